// File: rtl/lcd_pkg.sv
// Shared types and constants for the LCD panel bus driver.
package lcd_pkg;

    localparam int unsigned LCD_BUS_CNT_W = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        WR_LO = 3'd2,
        WR_HI = 3'd3,
        HOLD  = 3'd4
    } lcd_bus_state_t;

endpackage : lcd_pkg

// File: rtl/lcd_bus_drv.sv
// LCD 8080-style write-only bus driver: turns a valid/ready word stream into
// CSX/WRX/D-CX/data pin activity with programmable WRX low/high times.
// Optional feature macro: LCD_BUS_DRV_CS_IDLE_EN -- when defined, CSX is
// released after CS_IDLE_CYC idle cycles (HOLD state); when undefined, CSX
// stays asserted after reset and the FSM returns to IDLE after every word.
module lcd_bus_drv
    import lcd_pkg::*;
#(
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned WR_LOW_CYC  = 2,
    parameter int unsigned WR_HIGH_CYC = 2,
    parameter int unsigned CS_IDLE_CYC = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              rs_i,
    input  logic              valid_i,
    output logic              ready_o,
    output logic              lcd_cs_n_o,
    output logic              lcd_rs_o,
    output logic              lcd_wr_n_o,
    output logic              lcd_rd_n_o,
    output logic [DATA_W-1:0] lcd_data_o,
    output logic              busy_o
);

    localparam logic [LCD_BUS_CNT_W-1:0] LO_LD   = LCD_BUS_CNT_W'(WR_LOW_CYC - 1);
    localparam logic [LCD_BUS_CNT_W-1:0] HI_LD   = LCD_BUS_CNT_W'(WR_HIGH_CYC - 1);
    localparam logic [LCD_BUS_CNT_W-1:0] CNT_ONE = LCD_BUS_CNT_W'(1);
    localparam logic [LCD_BUS_CNT_W-1:0] CNT_Z   = '0;

    // Reject timing parameters outside what an 8-bit down-counter can express.
    if (WR_LOW_CYC < 1 || WR_LOW_CYC > 255) begin : g_bad_wr_low
        $error("lcd_bus_drv: WR_LOW_CYC out of range 1..255");
    end
    if (WR_HIGH_CYC < 1 || WR_HIGH_CYC > 255) begin : g_bad_wr_high
        $error("lcd_bus_drv: WR_HIGH_CYC out of range 1..255");
    end
    if (CS_IDLE_CYC < 1 || CS_IDLE_CYC > 255) begin : g_bad_cs_idle
        $error("lcd_bus_drv: CS_IDLE_CYC out of range 1..255");
    end

`ifdef LCD_BUS_DRV_CS_IDLE_EN
    localparam logic [LCD_BUS_CNT_W-1:0] IDLE_LD = LCD_BUS_CNT_W'(CS_IDLE_CYC - 1);
`endif

    lcd_bus_state_t             state_q, state_d;
    logic [LCD_BUS_CNT_W-1:0]   cnt_q, cnt_d;
    logic                       ready_q, ready_d;
    logic                       busy_q, busy_d;
    logic                       cs_n_q, cs_n_d;
    logic                       wr_n_q, wr_n_d;
    logic                       rs_q, rs_d;
    logic [DATA_W-1:0]          data_q, data_d;
    logic                       accept_c;

    assign accept_c = valid_i && ready_q;

    // State, counter and registered pin outputs; reset drops any word in flight.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            cs_n_q  <= 1'b1;
            wr_n_q  <= 1'b1;
            rs_q    <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            cs_n_q  <= cs_n_d;
            wr_n_q  <= wr_n_d;
            rs_q    <= rs_d;
            data_q  <= data_d;
        end
    end

    // Next state and phase counter; an accept at the end of a word chains
    // straight into the next WRX low phase.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (accept_c) begin
                    state_d = SETUP;
                    cnt_d   = CNT_Z;
                end
            end
            SETUP: begin
                state_d = WR_LO;
                cnt_d   = LO_LD;
            end
            WR_LO: begin
                if (cnt_q == CNT_Z) begin
                    state_d = WR_HI;
                    cnt_d   = HI_LD;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            WR_HI: begin
                if (cnt_q != CNT_Z) begin
                    cnt_d = cnt_q - CNT_ONE;
                end else if (accept_c) begin
                    state_d = WR_LO;
                    cnt_d   = LO_LD;
                end else begin
`ifdef LCD_BUS_DRV_CS_IDLE_EN
                    state_d = HOLD;
                    cnt_d   = IDLE_LD;
`else
                    state_d = IDLE;
                    cnt_d   = CNT_Z;
`endif
                end
            end
`ifdef LCD_BUS_DRV_CS_IDLE_EN
            HOLD: begin
                if (accept_c) begin
                    state_d = WR_LO;
                    cnt_d   = LO_LD;
                end else if (cnt_q == CNT_Z) begin
                    state_d = IDLE;
                    cnt_d   = CNT_Z;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
`endif
            default: begin
                state_d = IDLE;
                cnt_d   = CNT_Z;
            end
        endcase
    end

    // Pin and handshake values for the coming cycle, derived from the next state.
    always_comb begin
        ready_d = (state_d == IDLE) || (state_d == HOLD) ||
                  ((state_d == WR_HI) && (cnt_d == CNT_Z));
        busy_d  = (state_d != IDLE);
        wr_n_d  = (state_d != WR_LO);
`ifdef LCD_BUS_DRV_CS_IDLE_EN
        cs_n_d  = (state_d == IDLE);
`else
        cs_n_d  = 1'b0;
`endif
        rs_d    = rs_q;
        data_d  = data_q;
        if (accept_c) begin
            rs_d   = rs_i;
            data_d = data_i;
        end
    end

    assign ready_o    = ready_q;
    assign busy_o     = busy_q;
    assign lcd_cs_n_o = cs_n_q;
    assign lcd_wr_n_o = wr_n_q;
    assign lcd_rs_o   = rs_q;
    assign lcd_data_o = data_q;
    assign lcd_rd_n_o = 1'b1;

endmodule : lcd_bus_drv
